// File: rtl/ntt_stage_sched_if.sv
// ntt_stage_sched_if: control/address bundle between host run-mode logic
// (master) and the NTT schedule generator (slave).
//   start/kd_mode/intt/clr : host -> scheduler request and abort
//   stall                  : host -> scheduler freeze (NTT_SCHED_STALL_EN only)
//   busy/done/stage        : scheduler status
//   rd_valid/rd_addr/tf_idx: per-cycle read issue, lane l in slot [l]
//   wr_valid/wr_addr       : write-back issue, rd side delayed BF_LAT cycles
// Each address slot is {lower, upper}, with upper in the low half.
interface ntt_stage_sched_if #(
  parameter int LOG_N  = 8,
  parameter int NUM_BF = 2
);
  logic start, kd_mode, intt, clr;
`ifdef NTT_SCHED_STALL_EN
  logic stall;
`endif
  logic busy, done, rd_valid, wr_valid;
  logic [LOG_N-1:0]                  stage;
  logic [NUM_BF-1:0][2*LOG_N-1:0]    rd_addr, wr_addr;
  logic [NUM_BF-1:0][LOG_N-1:0]      tf_idx;

`ifdef NTT_SCHED_STALL_EN
  modport master (output start, kd_mode, intt, clr, stall,
                  input  busy, done, stage, rd_valid, rd_addr, tf_idx, wr_valid, wr_addr);
  modport slave  (input  start, kd_mode, intt, clr, stall,
                  output busy, done, stage, rd_valid, rd_addr, tf_idx, wr_valid, wr_addr);
`else
  modport master (output start, kd_mode, intt, clr,
                  input  busy, done, stage, rd_valid, rd_addr, tf_idx, wr_valid, wr_addr);
  modport slave  (input  start, kd_mode, intt, clr,
                  output busy, done, stage, rd_valid, rd_addr, tf_idx, wr_valid, wr_addr);
`endif
endinterface

// File: rtl/ntt_stage_sched.sv
// ntt_stage_sched: NTT/INTT address and twiddle schedule generator.
// Issues NUM_BF butterflies per cycle, P = N/(2*NUM_BF) issue cycles per
// stage, then a BF_LAT-cycle drain so the next stage never reads a
// coefficient that is still in flight. Write-back addresses are the read
// addresses pushed through a BF_LAT-deep delay line.
// Ports: clk, rst (async, active high), bus (ntt_stage_sched_if.slave).
// Optional: define NTT_SCHED_STALL_EN to add bus.stall, which freezes the
// counters, FSM and delay line and masks rd_valid/wr_valid.

// Per-lane address/twiddle math for butterfly index b at log2(len).
module ntt_sched_lane #(
  parameter int LOG_N = 8,
  parameter int LLW   = 3
) (
  input  logic [LOG_N-1:0]   b,
  input  logic [LLW-1:0]     log_len,
  input  logic               intt,
  output logic [2*LOG_N-1:0] addr,
  output logic [LOG_N-1:0]   tf
);
  localparam logic [LOG_N-1:0] HALF = {1'b1, {(LOG_N-1){1'b0}}};
  localparam logic [LOG_N-1:0] ONES = '1;
  logic [LOG_N-1:0] len, grp, pos, upper, lower;

  always_comb begin
    len   = LOG_N'(1) << log_len;
    grp   = b >> log_len;
    pos   = b & (len - LOG_N'(1));
    upper = ((grp << log_len) << 1) + pos;
    lower = upper + len;
    // N/len - 1 is a mask of LOG_N-log_len ones; this also stays exact
    // for len=1 where N itself does not fit in LOG_N bits.
    tf    = intt ? (ONES >> log_len) - grp : (HALF >> log_len) + grp;
    addr  = {lower, upper};
  end
endmodule

module ntt_stage_sched #(
  parameter int LOG_N  = 8,
  parameter int NUM_BF = 2,
  parameter int BF_LAT = 8
) (
  input logic clk,
  input logic rst,
  ntt_stage_sched_if.slave bus
);
  localparam int N   = 1 << LOG_N;
  localparam int P   = N / (2 * NUM_BF);
  localparam int LBF = $clog2(NUM_BF);
  localparam int CW  = (P > 1) ? $clog2(P) : 1;
  localparam int DW  = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam int LLW = (LOG_N > 1) ? $clog2(LOG_N) : 1;
  localparam int AW  = 2 * LOG_N;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                               state_q, state_d;
  logic [CW-1:0]                        c_q, c_d;
  logic [DW-1:0]                        dcnt_q, dcnt_d;
  logic [LOG_N-1:0]                     stage_q, stage_d;
  logic                                 kd_q, kd_d, intt_q, intt_d;
  logic [BF_LAT-1:0]                    vld_pipe_q, vld_pipe_d;
  logic [BF_LAT-1:0][NUM_BF-1:0][AW-1:0] addr_pipe_q, addr_pipe_d;

  logic                                 stall, hold, rd_valid, busy, done;
  logic [LOG_N-1:0]                     last_stage;
  logic [LLW-1:0]                       log_len;
  logic [NUM_BF-1:0][AW-1:0]            lane_addr, rd_addr;
  logic [NUM_BF-1:0][LOG_N-1:0]         lane_tf, tf_idx;

`ifdef NTT_SCHED_STALL_EN
  assign stall = bus.stall;
`else
  assign stall = 1'b0;
`endif
  // clr must still take effect while stalled
  assign hold = stall & ~bus.clr;

  assign last_stage = kd_q ? LOG_N'(LOG_N-1) : LOG_N'(LOG_N-2);
  // NTT: len = N>>(s+1); INTT: len = 1<<(s + (kd ? 0 : 1))
  assign log_len = intt_q ? LLW'(stage_q + {{(LOG_N-1){1'b0}}, ~kd_q})
                          : LLW'(LOG_N'(LOG_N-1) - stage_q);

  for (genvar l = 0; l < NUM_BF; l++) begin : g_lane
    logic [LOG_N-1:0] b;
    assign b = (LOG_N'(c_q) << LBF) | LOG_N'(l);
    ntt_sched_lane #(.LOG_N(LOG_N), .LLW(LLW)) u_lane (
      .b      (b),
      .log_len(log_len),
      .intt   (intt_q),
      .addr   (lane_addr[l]),
      .tf     (lane_tf[l])
    );
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      c_q         <= '0;
      dcnt_q      <= '0;
      stage_q     <= '0;
      kd_q        <= 1'b0;
      intt_q      <= 1'b0;
      vld_pipe_q  <= '0;
      addr_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      dcnt_q      <= dcnt_d;
      stage_q     <= stage_d;
      kd_q        <= kd_d;
      intt_q      <= intt_d;
      vld_pipe_q  <= vld_pipe_d;
      addr_pipe_q <= addr_pipe_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    dcnt_d  = dcnt_q;
    stage_d = stage_q;
    kd_d    = kd_q;
    intt_d  = intt_q;
    if (!hold) begin
      unique case (state_q)
        IDLE: if (bus.start) begin
          state_d = ISSUE;
          c_d     = '0;
          stage_d = '0;
          kd_d    = bus.kd_mode;
          intt_d  = bus.intt;
        end
        ISSUE: if (c_q == CW'(P-1)) begin
          state_d = DRAIN;
          c_d     = '0;
          dcnt_d  = '0;
        end else begin
          c_d = c_q + CW'(1);
        end
        DRAIN: if (dcnt_q == DW'(BF_LAT-1)) begin
          if (stage_q == last_stage) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            stage_d = stage_q + LOG_N'(1);
            c_d     = '0;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
        DONE: begin
          state_d = IDLE;
          stage_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
    if (bus.clr) begin
      state_d = IDLE;
      stage_d = '0;
      c_d     = '0;
      dcnt_d  = '0;
    end
  end

  // Outputs
  always_comb begin
    busy     = (state_q == ISSUE) || (state_q == DRAIN);
    done     = (state_q == DONE);
    rd_valid = (state_q == ISSUE) && !stall;
    rd_addr  = (state_q == ISSUE) ? lane_addr : '0;
    tf_idx   = (state_q == ISSUE) ? lane_tf   : '0;
  end

  // Write-back delay line; shifts in every state so nothing trails done
  always_comb begin
    vld_pipe_d  = vld_pipe_q;
    addr_pipe_d = addr_pipe_q;
    if (!hold) begin
      vld_pipe_d[0]  = rd_valid;
      addr_pipe_d[0] = rd_addr;
      for (int i = 1; i < BF_LAT; i++) begin
        vld_pipe_d[i]  = vld_pipe_q[i-1];
        addr_pipe_d[i] = addr_pipe_q[i-1];
      end
    end
    if (bus.clr) vld_pipe_d = '0;
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.stage    = stage_q;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_addr  = rd_addr;
  assign bus.tf_idx   = tf_idx;
  assign bus.wr_valid = vld_pipe_q[BF_LAT-1] & ~stall;
  assign bus.wr_addr  = addr_pipe_q[BF_LAT-1];
endmodule
